// File: rtl/ram_port_initiator_if.sv
// rtl/ram_port_initiator_if.sv - command/response handshake bundle for ram_port_initiator
interface ram_port_initiator_if #(
  parameter int AW = 10,
  parameter int DW = 18
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ram_port_initiator.sv
// rtl/ram_port_initiator.sv - credit-limited command/response initiator driving one RAM port
// Optional post-reset memory sweep: define RAM_CLEAR_ON_RESET_EN.
module ram_port_initiator #(
  parameter int RAM_WIDTH    = 18,
  parameter int RAM_DEPTH    = 1024,
  parameter int READ_LATENCY = 2,
  parameter int RSP_DEPTH    = 4,
  localparam int AW          = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                 clka,
  input  logic                 rsta_n,
  ram_port_initiator_if.slave  bus,
  output logic [AW-1:0]        ram_addr,
  output logic [RAM_WIDTH-1:0] ram_din,
  output logic                 ram_we,
  output logic                 ram_en,
  output logic                 ram_regce,
  output logic                 ram_rst,
  input  logic [RAM_WIDTH-1:0] ram_dout,
  output logic                 init_done
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = PW + 2;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("ram_port_initiator: READ_LATENCY must be 1 or 2");
  end
  if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_rsp_depth
    $error("ram_port_initiator: RSP_DEPTH must be a power of two >= 2");
  end

  logic                    in_run;
  logic                    in_clear;
  logic [AW-1:0]           clr_addr;
  logic                    cmd_ready_int;
  logic                    cmd_acc;
  logic                    rd_acc;
  logic                    push;
  logic                    pop;
  logic                    rsp_valid_int;
  logic [READ_LATENCY-1:0] pipe_q;
  logic [1:0]              inflight;
  logic [CW-1:0]           credits;
  logic [RAM_WIDTH-1:0]    fifo_mem [RSP_DEPTH];
  logic [PW-1:0]           wr_ptr_q;
  logic [PW-1:0]           rd_ptr_q;
  logic [PW:0]             count_q;

`ifdef RAM_CLEAR_ON_RESET_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] clr_cnt_q;
  logic [AW-1:0] clr_cnt_d;

  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      if (clr_cnt_q == AW'(RAM_DEPTH - 1)) begin
        state_d = ST_RUN;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
  end

  assign in_run   = rsta_n && (state_q == ST_RUN);
  assign in_clear = rsta_n && (state_q == ST_CLEAR);
  assign clr_addr = clr_cnt_q;
`else
  assign in_run   = rsta_n;
  assign in_clear = 1'b0;
  assign clr_addr = '0;
`endif

  // Credits count reads in the RAM pipe plus queued responses, so the FIFO can never overflow.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + {1'b0, pipe_q[i]};
    end
    credits = CW'(inflight) + CW'(count_q);
  end

  assign cmd_ready_int = in_run && (credits < CW'(RSP_DEPTH));
  assign cmd_acc       = bus.cmd_valid && cmd_ready_int;
  assign rd_acc        = cmd_acc && !bus.cmd_we;
  assign bus.cmd_ready = cmd_ready_int;

  always_comb begin
    ram_en   = in_clear | cmd_acc;
    ram_we   = in_clear | (cmd_acc & bus.cmd_we);
    ram_addr = in_clear ? clr_addr : bus.cmd_addr;
    ram_din  = in_clear ? '0 : bus.cmd_wdata;
  end

  assign ram_regce = (READ_LATENCY == 2) ? (rsta_n && pipe_q[0]) : 1'b0;
  assign init_done = in_run;

  always_ff @(posedge clka) begin
    ram_rst <= ~rsta_n;
  end

  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= rd_acc;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign push          = pipe_q[READ_LATENCY-1];
  assign rsp_valid_int = rsta_n && (count_q != '0);
  assign pop           = rsp_valid_int && bus.rsp_ready;
  assign bus.rsp_valid = rsp_valid_int;
  assign bus.rsp_rdata = fifo_mem[rd_ptr_q];

  always_ff @(posedge clka) begin
    if (rsta_n && push) begin
      fifo_mem[wr_ptr_q] <= ram_dout;
    end
  end

  // Pointers are PW bits wide, so they wrap modulo RSP_DEPTH on their own.
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: doc/ram_port_initiator.md
RAM_PORT_INITIATOR -- requirements
Module: ram_port_initiator

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 18: data width of the command, response and RAM data buses.
REQ-002 SHALL have parameter RAM_DEPTH, default 1024: number of RAM entries; AW = clogb2(RAM_DEPTH-1).
REQ-003 SHALL have parameter READ_LATENCY, default 2: 1 for a LOW_LATENCY RAM port, 2 for a HIGH_PERFORMANCE RAM port; any other value is an elaboration error.
REQ-004 SHALL have parameter RSP_DEPTH, default 4: response FIFO entries, power of two, ≥2.
REQ-005 clka  in  1  sole clock; all logic on posedge.
REQ-006 rsta_n  in  1  reset: synchronous, active-low.
REQ-007 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-008 cmd_we  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  AW  command address.
REQ-010 cmd_wdata  in  RAM_WIDTH  write data.
REQ-011 rsp_valid / rsp_ready  out / in  1 / 1  read-response handshake.
REQ-012 rsp_rdata  out  RAM_WIDTH  read data, in command order.
REQ-013 ram_addr, ram_din, ram_we, ram_en, ram_regce, ram_rst  out  AW, RAM_WIDTH, 1, 1, 1, 1  drive one RAM port.
REQ-014 ram_dout  in  RAM_WIDTH  RAM port output data.
REQ-015 init_done  out  1  high once the block is in RUN.

Function
REQ-016 States SHALL be CLEAR and RUN; CLEAR exists only with the macro from REQ-030; otherwise reset enters RUN directly.
REQ-017 A command SHALL be accepted on any cycle with cmd_valid && cmd_ready.
REQ-018 In RUN, ram_en = cmd_valid && cmd_ready, combinationally; ram_we = ram_en && cmd_we; ram_addr = cmd_addr; ram_din = cmd_wdata.
REQ-019 Credits = reads in flight + FIFO occupancy, both registered.
REQ-020 cmd_ready SHALL be 1 iff state == RUN and credits < RSP_DEPTH.
  - The condition is independent of cmd_we and cmd_valid.
  - A pop in the same cycle does not free a credit until the next cycle.
REQ-021 Each accepted read SHALL enter a READ_LATENCY-stage valid shift register (pipe[0] set at the accept edge).
  - ram_regce = pipe[0] when READ_LATENCY == 2; ram_regce = 0 when READ_LATENCY == 1.
REQ-022 When pipe[READ_LATENCY-1] = 1, ram_dout SHALL be pushed into the response FIFO at that edge.
  - Read-to-rsp_valid latency: READ_LATENCY+1 cycles when the FIFO is empty.
REQ-023 rsp_valid = FIFO not empty; rsp_rdata = FIFO head; pop on rsp_valid && rsp_ready.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
REQ-024 FIFO overflow SHALL be impossible by REQ-020; read/write pointers wrap modulo RSP_DEPTH.
REQ-025 Writes SHALL produce no response and consume no credit after the accept cycle.
REQ-026 Back-to-back reads and writes SHALL be accepted one per cycle while credits remain; data order is preserved.

Reset
REQ-027 While rsta_n = 0 at a clock edge, the following SHALL be cleared:
  - state → CLEAR (macro defined) or RUN (macro undefined);
  - pipe and FIFO pointers/occupancy → 0;
  - the clear counter → 0.
REQ-028 Output values during reset:
  - rsp_valid = 0, cmd_ready = 0, init_done = 0;
  - ram_en = 0, ram_we = 0, ram_regce = 0;
  - ram_rst = 1 (ram_rst = ~rsta_n, registered).
REQ-029 Reset mid-operation SHALL discard in-flight reads and queued responses; no stale response appears after release.

Configuration
REQ-030 Macro RAM_CLEAR_ON_RESET_EN defined: after reset release the block SHALL sweep in CLEAR.
  - Per cycle: ram_en = 1, ram_we = 1, ram_din = 0, ram_addr = counter 0..RAM_DEPTH-1.
  - Exactly RAM_DEPTH cycles, then RUN.
  - cmd_ready = 0 and init_done = 0 throughout the sweep.
REQ-031 Macro undefined: no CLEAR state or counter; init_done = 1 and RUN from the first cycle after reset release.

Verification
REQ-032 READ_LATENCY=2: write addr 5 = 18'h2A5A5, then read addr 5 with rsp_ready=1.
  - ram_regce pulses 1 cycle after the read accept.
  - rsp_valid 3 cycles after the read accept; rsp_rdata = 18'h2A5A5.
REQ-033 READ_LATENCY=1, RSP_DEPTH=4, rsp_ready=0, continuous reads of addr 0..7.
  - Exactly 4 accepted, then cmd_ready = 0.
  - Raising rsp_ready drains responses in order 0,1,2,3; further reads then resume.
REQ-034 Alternating write/read every cycle (wr a=n data=n, rd a=n) for n = 0..15.
  - 16 responses with data 0..15 in order; no dropped cycles while credits remain.
REQ-035 rsta_n low for 1 cycle with 2 reads in flight and 2 queued.
  - No rsp_valid after release until a new read completes; ram_rst = 1 during the reset cycle.
REQ-036 RAM_CLEAR_ON_RESET_EN defined, RAM_DEPTH=16, memory preloaded with nonzero values.
  - 16 clear writes to addr 0..15, then init_done = 1.
  - A subsequent read of every address returns 0.
